// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester
//
// Soak tester for the user write/read request ports of the SDRAM controller.
// Each pass fills MEM_WORDS words in BURST-word bursts with a selectable
// pattern, reads them back and compares every beat. Pass and error counters
// saturate at 16'hFFFF.
//
// Optional feature macro: SDRAM_TESTER_ERRCAP_EN
//   defined     -> err_addr/err_data hold the first mismatch since reset/clear
//   not defined -> err_addr/err_data are tied to zero, no capture registers
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for run
// WR_REQ   | write request raised, waiting for user_wstart
// WR_BURST | write burst in flight, one word per user_wen
// RD_REQ   | read request raised, waiting for user_rstart
// RD_BURST | read burst in flight, one compare per user_rvalid
// PASS_END | pass complete: toggle status, count the pass

module sdram_pattern_tester #(
    parameter int              ADDR_W    = 24,
    parameter int              DATA_W    = 16,
    parameter int              SIZE_W    = 10,
    parameter int              BURST     = 256,
    parameter longint unsigned MEM_WORDS = 64'd16777216
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [1:0]        mode,
    input  logic              clear,
    output logic              user_wreq,
    input  logic              user_wstart,
    input  logic              user_wdone,
    output logic [ADDR_W-1:0] user_waddr,
    output logic [SIZE_W-1:0] user_wsize,
    input  logic              user_wen,
    output logic [DATA_W-1:0] user_wdata,
    output logic              user_rreq,
    input  logic              user_rstart,
    input  logic              user_rdone,
    output logic [ADDR_W-1:0] user_raddr,
    output logic [SIZE_W-1:0] user_rsize,
    input  logic              user_rvalid,
    input  logic [DATA_W-1:0] user_rdata,
    output logic              status,
    output logic              err_strobe,
    output logic              err_latch,
    output logic [15:0]       pass_count,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_REQ   = 3'd1,
        WR_BURST = 3'd2,
        RD_REQ   = 3'd3,
        RD_BURST = 3'd4,
        PASS_END = 3'd5
    } state_t;

    // A region covering the whole address space ends when the address wraps.
    localparam longint unsigned SPACE      = 64'd1 << ADDR_W;
    localparam bit              FULL_SPACE = (MEM_WORDS >= SPACE);
    localparam logic [ADDR_W-1:0] END_ADDR = ADDR_W'(MEM_WORDS % SPACE);
    localparam logic [SIZE_W-1:0] BURST_SZ = SIZE_W'(BURST);
    localparam int                IDX_W    = $clog2(DATA_W);
    localparam logic [15:0]       LFSR_TAG = 16'hACE1;

    function automatic logic more_words(input logic [ADDR_W-1:0] a);
        if (FULL_SPACE) return (a != '0);
        else            return (a < END_ADDR);
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0]        m,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [31:0]       l);
        logic [ADDR_W+DATA_W-1:0] ext;
        logic [DATA_W-1:0]        base;
        logic [DATA_W-1:0]        one;
        ext  = {{DATA_W{1'b0}}, a};
        base = ext[DATA_W-1:0];
        one  = {{(DATA_W-1){1'b0}}, 1'b1};
        case (m)
            2'd0:    return base;
            2'd1:    return l[DATA_W-1:0];
            2'd2:    return one << a[IDX_W-1:0];
            default: return ~base;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [31:0]       seed_q, seed_d;
    logic              status_q, status_d;
    logic              wreq_q, wreq_d;
    logic              rreq_q, rreq_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [SIZE_W-1:0] wsize_q, wsize_d;
    logic [SIZE_W-1:0] rsize_q, rsize_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_strobe_q, err_strobe_d;
    logic              err_latch_q, err_latch_d;
    logic [15:0]       pass_cnt_q, pass_cnt_d;
    logic [15:0]       err_cnt_q, err_cnt_d;
    logic [15:0]       pass_base, err_base;
    logic [DATA_W-1:0] expected;
    logic              mismatch;

    // Pass counter: clear first, then the pass completing in PASS_END.
    always_comb begin
        pass_base  = clear ? 16'd0 : pass_cnt_q;
        pass_cnt_d = (state_q == PASS_END) ? sat_inc(pass_base) : pass_base;
    end

    // Sequencer next state, address counter and pattern generator.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        addr_d   = addr_q;
        lfsr_d   = lfsr_q;
        seed_d   = seed_q;
        status_d = status_q;
        unique case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = WR_REQ;
                    mode_d  = mode;
                    addr_d  = '0;
                    seed_d  = {LFSR_TAG, pass_cnt_d};
                    lfsr_d  = seed_d;
                end
            end
            WR_REQ: begin
                if (user_wstart) state_d = WR_BURST;
            end
            WR_BURST: begin
                // A beat arriving with wdone is counted before the phase check.
                if (user_wen) begin
                    addr_d = addr_q + 1'b1;
                    lfsr_d = lfsr_step(lfsr_q);
                end
                if (user_wdone) begin
                    if (more_words(addr_d)) begin
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_REQ;
                        addr_d  = '0;
                        lfsr_d  = seed_q;
                    end
                end
            end
            RD_REQ: begin
                if (user_rstart) state_d = RD_BURST;
            end
            RD_BURST: begin
                if (user_rvalid) begin
                    addr_d = addr_q + 1'b1;
                    lfsr_d = lfsr_step(lfsr_q);
                end
                if (user_rdone) begin
                    state_d = more_words(addr_d) ? RD_REQ : PASS_END;
                end
            end
            PASS_END: begin
                status_d = ~status_q;
                if (run) begin
                    state_d = WR_REQ;
                    mode_d  = mode;
                    addr_d  = '0;
                    seed_d  = {LFSR_TAG, pass_cnt_d};
                    lfsr_d  = seed_d;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request-port outputs are registered from the next state so they are
    // valid on the first cycle of WR_REQ/RD_REQ and zero outside their phase.
    always_comb begin
        wreq_d  = (state_d == WR_REQ);
        rreq_d  = (state_d == RD_REQ);
        waddr_d = '0;
        raddr_d = '0;
        wsize_d = '0;
        rsize_d = '0;
        wdata_d = '0;
        if (state_d == WR_REQ || state_d == WR_BURST) begin
            wsize_d = BURST_SZ;
            wdata_d = pattern(mode_d, addr_d, lfsr_d);
            waddr_d = (state_d == WR_REQ) ? addr_d : waddr_q;
        end
        if (state_d == RD_REQ || state_d == RD_BURST) begin
            rsize_d = BURST_SZ;
            raddr_d = (state_d == RD_REQ) ? addr_d : raddr_q;
        end
    end

    // Read compare; a mismatch in the same cycle as clear still counts.
    always_comb begin
        expected     = pattern(mode_q, addr_q, lfsr_q);
        mismatch     = (state_q == RD_BURST) && user_rvalid && (user_rdata != expected);
        err_strobe_d = mismatch;
        err_latch_d  = mismatch | (err_latch_q & ~clear);
        err_base     = clear ? 16'd0 : err_cnt_q;
        err_cnt_d    = mismatch ? sat_inc(err_base) : err_base;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            mode_q       <= 2'd0;
            addr_q       <= '0;
            lfsr_q       <= '0;
            seed_q       <= '0;
            status_q     <= 1'b0;
            wreq_q       <= 1'b0;
            rreq_q       <= 1'b0;
            waddr_q      <= '0;
            raddr_q      <= '0;
            wsize_q      <= '0;
            rsize_q      <= '0;
            wdata_q      <= '0;
            err_strobe_q <= 1'b0;
            err_latch_q  <= 1'b0;
            pass_cnt_q   <= 16'd0;
            err_cnt_q    <= 16'd0;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            addr_q       <= addr_d;
            lfsr_q       <= lfsr_d;
            seed_q       <= seed_d;
            status_q     <= status_d;
            wreq_q       <= wreq_d;
            rreq_q       <= rreq_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            wsize_q      <= wsize_d;
            rsize_q      <= rsize_d;
            wdata_q      <= wdata_d;
            err_strobe_q <= err_strobe_d;
            err_latch_q  <= err_latch_d;
            pass_cnt_q   <= pass_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

`ifdef SDRAM_TESTER_ERRCAP_EN
    logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
    logic [DATA_W-1:0] cap_data_q, cap_data_d;

    // First-mismatch capture; a mismatch coinciding with clear is the new first.
    always_comb begin
        cap_addr_d = clear ? '0 : cap_addr_q;
        cap_data_d = clear ? '0 : cap_data_q;
        if (mismatch && (!err_latch_q || clear)) begin
            cap_addr_d = addr_q;
            cap_data_d = user_rdata;
        end
    end

    // Capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_addr_q <= '0;
            cap_data_q <= '0;
        end else begin
            cap_addr_q <= cap_addr_d;
            cap_data_q <= cap_data_d;
        end
    end

    assign err_addr = cap_addr_q;
    assign err_data = cap_data_q;
`else
    assign err_addr = '0;
    assign err_data = '0;
`endif

    assign user_wreq  = wreq_q;
    assign user_rreq  = rreq_q;
    assign user_waddr = waddr_q;
    assign user_raddr = raddr_q;
    assign user_wsize = wsize_q;
    assign user_rsize = rsize_q;
    assign user_wdata = wdata_q;
    assign status     = status_q;
    assign err_strobe = err_strobe_q;
    assign err_latch  = err_latch_q;
    assign pass_count = pass_cnt_q;
    assign err_count  = err_cnt_q;

endmodule

// File: tb/tb_sdram_pattern_tester.sv
// Bench for sdram_pattern_tester: a behavioural controller with an ideal
// 512-word memory (optional bit-3 flip at address 300) drives the user ports.
module tb_sdram_pattern_tester;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 16;
    localparam int SIZE_W = 10;
    localparam int BURST  = 256;
    localparam int WORDS  = 512;

    localparam int C_IDLE = 0;
    localparam int C_WR   = 1;
    localparam int C_RD   = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run = 1'b0;
    logic [1:0]        mode = 2'd0;
    logic              clear = 1'b0;
    logic              user_wreq, user_rreq;
    logic              user_wstart = 1'b0, user_wdone = 1'b0, user_wen = 1'b0;
    logic              user_rstart = 1'b0, user_rdone = 1'b0, user_rvalid = 1'b0;
    logic [ADDR_W-1:0] user_waddr, user_raddr;
    logic [SIZE_W-1:0] user_wsize, user_rsize;
    logic [DATA_W-1:0] user_wdata;
    logic [DATA_W-1:0] user_rdata = '0;
    logic              status, err_strobe, err_latch;
    logic [15:0]       pass_count, err_count;
    logic [ADDR_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;

    int checks = 0;
    int errors = 0;

    // controller model state and observation counters
    logic [15:0] mem [0:WORDS-1];
    int c_state = C_IDLE, c_cnt = 0, c_addr = 0, c_wait = 0;
    int wdelay = 0;
    bit flip_en = 0, clear_on_flip = 0, clear_by_ctl = 0, exp_strobe = 0;
    int strobe_cnt = 0, strobe_bad = 0;
    int wbursts = 0, rbursts = 0;
    int wreq_len = 0, last_wreq_len = 0, waddr_moved = 0;
    logic [ADDR_W-1:0] wreq_addr = '0;
    logic [ADDR_W-1:0] waddr_log [$];
    logic [ADDR_W-1:0] raddr_log [$];
    logic [DATA_W-1:0] w0_log [$];
    logic [SIZE_W-1:0] wsize_seen = '0, rsize_seen = '0;

    sdram_pattern_tester #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
        .BURST(BURST), .MEM_WORDS(64'd512)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode(mode), .clear(clear),
        .user_wreq(user_wreq), .user_wstart(user_wstart), .user_wdone(user_wdone),
        .user_waddr(user_waddr), .user_wsize(user_wsize), .user_wen(user_wen),
        .user_wdata(user_wdata),
        .user_rreq(user_rreq), .user_rstart(user_rstart), .user_rdone(user_rdone),
        .user_raddr(user_raddr), .user_rsize(user_rsize), .user_rvalid(user_rvalid),
        .user_rdata(user_rdata),
        .status(status), .err_strobe(err_strobe), .err_latch(err_latch),
        .pass_count(pass_count), .err_count(err_count),
        .err_addr(err_addr), .err_data(err_data)
    );

    always #5 clk = ~clk;

    // Controller model: all inputs driven and outputs sampled at the negedge.
    initial begin
        int idx;
        for (int i = 0; i < WORDS; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (err_strobe) strobe_cnt++;
            if (err_strobe !== exp_strobe) strobe_bad++;
            exp_strobe = 0;
            if (user_wreq) begin
                if (wreq_len == 0) wreq_addr = user_waddr;
                else if (user_waddr !== wreq_addr) waddr_moved++;
                wreq_len++;
            end else if (wreq_len != 0) begin
                last_wreq_len = wreq_len;
                wreq_len = 0;
            end
            user_wstart = 0; user_wen = 0; user_wdone = 0;
            user_rstart = 0; user_rvalid = 0; user_rdone = 0;
            if (clear_by_ctl) begin clear = 0; clear_by_ctl = 0; end
            if (!rst_n) begin
                c_state = C_IDLE; c_wait = 0; c_cnt = 0;
            end else begin
                case (c_state)
                    C_IDLE: begin
                        if (user_wreq) begin
                            if (c_wait < wdelay) c_wait++;
                            else begin
                                user_wstart = 1; c_wait = 0; c_cnt = 0;
                                c_addr = int'(user_waddr); c_state = C_WR;
                                wbursts++; waddr_log.push_back(user_waddr);
                                wsize_seen = user_wsize;
                            end
                        end else if (user_rreq) begin
                            user_rstart = 1; c_cnt = 0;
                            c_addr = int'(user_raddr); c_state = C_RD;
                            rbursts++; raddr_log.push_back(user_raddr);
                            rsize_seen = user_rsize;
                        end
                    end
                    C_WR: begin
                        idx = (c_addr + c_cnt) % WORDS;
                        user_wen = 1;
                        mem[idx] = user_wdata;
                        if (idx == 0) w0_log.push_back(user_wdata);
                        c_cnt++;
                        if (c_cnt == BURST) begin user_wdone = 1; c_state = C_IDLE; end
                    end
                    default: begin
                        idx = (c_addr + c_cnt) % WORDS;
                        user_rvalid = 1;
                        user_rdata = mem[idx];
                        if (flip_en && idx == 300) begin
                            user_rdata = mem[idx] ^ 16'h0008;
                            exp_strobe = 1;
                            if (clear_on_flip) begin
                                clear = 1; clear_by_ctl = 1; clear_on_flip = 0;
                            end
                        end
                        c_cnt++;
                        if (c_cnt == BURST) begin user_rdone = 1; c_state = C_IDLE; end
                    end
                endcase
            end
        end
    end

    task automatic pulse_clear();
        @(negedge clk); clear = 1;
        @(negedge clk); clear = 0;
    endtask

    // Runs exactly n passes, dropping run so the DUT returns to IDLE afterwards.
    task automatic run_passes(input int n);
        int toggles = 0;
        int cyc = 0;
        logic st;
        @(negedge clk); run = 1; st = status;
        while (!user_wreq && cyc < 200) begin @(negedge clk); cyc++; end
        if (n == 1) run = 0;
        cyc = 0;
        while (toggles < n && cyc < n * 4000) begin
            @(negedge clk); cyc++;
            if (status !== st) begin
                st = status; toggles++;
                if (toggles == n - 1) run = 0;
            end
        end
        run = 0;
        checks++;
        if (toggles != n) begin
            errors++;
            $display("FAIL pass_timeout toggles %0d want %0d", toggles, n);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({user_wreq, user_rreq, status, err_strobe, err_latch} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got %b want 00000",
                               {user_wreq, user_rreq, status, err_strobe, err_latch});
        end
        checks++;
        if (user_waddr !== '0 || user_raddr !== '0 || user_wsize !== '0 ||
            user_rsize !== '0 || user_wdata !== '0) begin
            errors++; $display("FAIL reset_req got waddr %0h wsize %0h wdata %0h want 0",
                               user_waddr, user_wsize, user_wdata);
        end
        checks++;
        if (pass_count !== 16'd0 || err_count !== 16'd0 || err_addr !== '0 || err_data !== '0) begin
            errors++; $display("FAIL reset_counts got pass %0h err %0h want 0", pass_count, err_count);
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_mode0();
        int wb0 = wbursts;
        int rb0 = rbursts;
        mode = 2'd0;
        waddr_log.delete(); raddr_log.delete();
        run_passes(1);
        checks++;
        if (pass_count !== 16'd1 || status !== 1'b1 || err_count !== 16'd0) begin
            errors++; $display("FAIL mode0_counts got pass %0d status %b err %0d want 1 1 0",
                               pass_count, status, err_count);
        end
        checks++;
        if (wbursts - wb0 != 2 || rbursts - rb0 != 2) begin
            errors++; $display("FAIL mode0_bursts got w %0d r %0d want 2 2", wbursts - wb0, rbursts - rb0);
        end
        checks++;
        if (waddr_log.size() != 2 || waddr_log[0] !== 24'd0 || waddr_log[1] !== 24'd256) begin
            errors++; $display("FAIL mode0_waddr got size %0d want 0,256", waddr_log.size());
        end
        checks++;
        if (raddr_log.size() != 2 || raddr_log[0] !== 24'd0 || raddr_log[1] !== 24'd256) begin
            errors++; $display("FAIL mode0_raddr got size %0d want 0,256", raddr_log.size());
        end
        checks++;
        if (wsize_seen !== 10'd256 || rsize_seen !== 10'd256) begin
            errors++; $display("FAIL burst_size got %0d %0d want 256", wsize_seen, rsize_seen);
        end
        checks++;
        if (mem[5] !== 16'd5 || mem[300] !== 16'd300 || mem[511] !== 16'd511) begin
            errors++; $display("FAIL mode0_data got %0h %0h %0h want 5 12c 1ff", mem[5], mem[300], mem[511]);
        end
        checks++;
        if (strobe_cnt != 0 || user_wreq !== 1'b0) begin
            errors++; $display("FAIL mode0_idle got strobes %0d wreq %b want 0 0", strobe_cnt, user_wreq);
        end
    endtask

    task automatic test_lfsr();
        mode = 2'd1;
        pulse_clear();
        w0_log.delete();
        run_passes(3);
        checks++;
        if (pass_count !== 16'd3 || err_count !== 16'd0) begin
            errors++; $display("FAIL lfsr_counts got pass %0d err %0d want 3 0", pass_count, err_count);
        end
        checks++;
        if (w0_log.size() != 3 || w0_log[0] !== 16'h0000 || w0_log[1] !== 16'h0001 || w0_log[2] !== 16'h0002) begin
            errors++; $display("FAIL lfsr_seed got size %0d want words 0,1,2", w0_log.size());
        end
        checks++;
        if (mem[1] !== 16'h0005 || mem[2] !== 16'h000B) begin
            errors++; $display("FAIL lfsr_step got %0h %0h want 5 b", mem[1], mem[2]);
        end
    endtask

    task automatic test_walking_one();
        mode = 2'd2;
        run_passes(1);
        checks++;
        if (mem[0] !== 16'h0001 || mem[17] !== 16'h0002 || mem[300] !== 16'h1000 || mem[15] !== 16'h8000) begin
            errors++; $display("FAIL walk_data got %0h %0h %0h %0h want 1 2 1000 8000",
                               mem[0], mem[17], mem[300], mem[15]);
        end
        checks++;
        if (err_count !== 16'd0) begin
            errors++; $display("FAIL walk_err got %0d want 0", err_count);
        end
    endtask

    task automatic test_error_count();
        mode = 2'd3;
        pulse_clear();
        strobe_cnt = 0; strobe_bad = 0;
        flip_en = 1;
        run_passes(1);
        checks++;
        if (err_count !== 16'd1 || strobe_cnt != 1 || err_latch !== 1'b1) begin
            errors++; $display("FAIL err_pass1 got cnt %0d strobes %0d latch %b want 1 1 1",
                               err_count, strobe_cnt, err_latch);
        end
        run_passes(1);
        checks++;
        if (err_count !== 16'd2 || strobe_cnt != 2) begin
            errors++; $display("FAIL err_pass2 got cnt %0d strobes %0d want 2 2", err_count, strobe_cnt);
        end
        checks++;
        if (strobe_bad != 0) begin
            errors++; $display("FAIL strobe_timing got %0d misplaced want 0", strobe_bad);
        end
        checks++;
        if (mem[300] !== 16'hFED3) begin
            errors++; $display("FAIL inv_data got %0h want fed3", mem[300]);
        end
        checks++;
`ifdef SDRAM_TESTER_ERRCAP_EN
        if (err_addr !== 24'd300 || err_data !== 16'hFEDB) begin
            errors++; $display("FAIL err_capture got %0d %0h want 300 fedb", err_addr, err_data);
        end
`else
        if (err_addr !== 24'd0 || err_data !== 16'h0000) begin
            errors++; $display("FAIL err_capture got %0d %0h want 0 0", err_addr, err_data);
        end
`endif
    endtask

    task automatic test_clear_collision();
        clear_on_flip = 1;
        run_passes(1);
        checks++;
        if (err_count !== 16'd1 || err_latch !== 1'b1 || pass_count !== 16'd1) begin
            errors++; $display("FAIL clear_collide got cnt %0d latch %b pass %0d want 1 1 1",
                               err_count, err_latch, pass_count);
        end
`ifdef SDRAM_TESTER_ERRCAP_EN
        checks++;
        if (err_addr !== 24'd300) begin
            errors++; $display("FAIL clear_capture got %0d want 300", err_addr);
        end
`endif
        flip_en = 0;
        pulse_clear();
        #1;
        checks++;
        if (err_count !== 16'd0 || err_latch !== 1'b0 || pass_count !== 16'd0 || err_addr !== '0) begin
            errors++; $display("FAIL clear_plain got cnt %0d latch %b pass %0d addr %0d want 0",
                               err_count, err_latch, pass_count, err_addr);
        end
    endtask

    task automatic test_wstart_delay();
        int wb0 = wbursts;
        mode = 2'd0;
        wdelay = 50;
        waddr_moved = 0;
        run_passes(1);
        wdelay = 0;
        checks++;
        if (last_wreq_len != 51 || waddr_moved != 0) begin
            errors++; $display("FAIL wstart_wait got len %0d moved %0d want 51 0", last_wreq_len, waddr_moved);
        end
        checks++;
        if (wbursts - wb0 != 2 || pass_count !== 16'd1 || err_count !== 16'd0) begin
            errors++; $display("FAIL wstart_bursts got %0d pass %0d err %0d want 2 1 0",
                               wbursts - wb0, pass_count, err_count);
        end
    endtask

    task automatic test_reset_mid_burst();
        int cyc = 0;
        mode = 2'd0;
        @(negedge clk); run = 1;
        while (!(c_state == C_WR && c_cnt >= 100) && cyc < 1000) begin @(negedge clk); cyc++; end
        checks++;
        if (cyc >= 1000) begin
            errors++; $display("FAIL midburst_reach got timeout want write burst");
        end
        rst_n = 0;
        #2;
        checks++;
        if (user_wreq !== 1'b0 || user_wdata !== '0 || user_waddr !== '0 || user_wsize !== '0 ||
            pass_count !== 16'd0 || status !== 1'b0) begin
            errors++; $display("FAIL midburst_reset got wreq %b wdata %0h pass %0d status %b want 0",
                               user_wreq, user_wdata, pass_count, status);
        end
        repeat (3) @(negedge clk);
        rst_n = 1;
        cyc = 0;
        while (!user_wreq && cyc < 100) begin @(negedge clk); cyc++; end
        run = 0;
        checks++;
        if (user_wreq !== 1'b1 || user_waddr !== 24'd0 || user_wdata !== 16'd0) begin
            errors++; $display("FAIL restart_addr got wreq %b waddr %0d wdata %0h want 1 0 0",
                               user_wreq, user_waddr, user_wdata);
        end
        cyc = 0;
        while (status !== 1'b1 && cyc < 4000) begin @(negedge clk); cyc++; end
        repeat (5) @(negedge clk);
        checks++;
        if (pass_count !== 16'd1 || err_count !== 16'd0) begin
            errors++; $display("FAIL restart_pass got pass %0d err %0d want 1 0", pass_count, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_lfsr();
        test_walking_one();
        test_error_count();
        test_clear_collision();
        test_wstart_delay();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
